// File: rtl/lw_stall_scoreboard.sv
// Load-use hazard unit: per-register countdown scoreboard of in-flight loads driving the decode stall.
// Optional macro SW_FWD_EN lets a store whose data register is one cycle from ready proceed (MEM->MEM forward).
module lw_stall_scoreboard #(
  parameter int               REG_W     = 5,
  parameter int               NUM_REGS  = 32,
  parameter int               OPC_W     = 5,
  parameter logic [OPC_W-1:0] LW_OPCODE = 5'b01000,
  parameter logic [OPC_W-1:0] SW_OPCODE = 5'b00111,
  parameter int               LOAD_LAT  = 1,
  parameter int               CNT_W     = 16
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                dec_valid,
  input  logic                dec_is_noop,
  input  logic [OPC_W-1:0]    dec_opcode,
  input  logic [REG_W-1:0]    dec_rd,
  input  logic [REG_W-1:0]    dec_rs,
  input  logic [REG_W-1:0]    dec_rt,
  input  logic                dec_uses_rt,
  input  logic                flush,
  output logic                stall,
  output logic [NUM_REGS-1:0] busy_vec,
  output logic [CNT_W-1:0]    stall_count
);

  typedef logic [2:0] cnt_t;
  localparam cnt_t LAT = cnt_t'(LOAD_LAT);

  cnt_t                counter_q [NUM_REGS];
  cnt_t                counter_d [NUM_REGS];
  logic [NUM_REGS-1:0] busy;
  logic [CNT_W-1:0]    stallCount_q;
  logic                hazardRs;
  logic                hazardRt;
  logic                storeFwd;
  logic                issue;
  logic                loadIssue;

  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      busy[i] = (counter_q[i] != 3'd0);
    end
  end

  assign hazardRs = busy[dec_rs];
  assign hazardRt = dec_uses_rt & busy[dec_rt];

`ifdef SW_FWD_EN
  // Store data can be forwarded from MEM when the load lands in the very next cycle.
  assign storeFwd = (dec_opcode == SW_OPCODE) & ~hazardRs & hazardRt & (counter_q[dec_rt] == 3'd1);
`else
  assign storeFwd = 1'b0;
`endif

  assign stall     = dec_valid & ~dec_is_noop & ~flush & (hazardRs | hazardRt) & ~storeFwd;
  assign issue     = dec_valid & ~dec_is_noop & ~stall & ~flush;
  assign loadIssue = issue & (dec_opcode == LW_OPCODE);

  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      counter_d[i] = counter_q[i];
      if (flush) begin
        counter_d[i] = 3'd0;
      end else if (loadIssue && (dec_rd == REG_W'(i)) && (i != 0)) begin
        counter_d[i] = LAT;
      end else if (counter_q[i] != 3'd0) begin
        counter_d[i] = counter_q[i] - 3'd1;
      end
    end
    counter_d[0] = 3'd0;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        counter_q[i] <= 3'd0;
      end
      stallCount_q <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        counter_q[i] <= counter_d[i];
      end
      if (stall && (stallCount_q != {CNT_W{1'b1}})) begin
        stallCount_q <= stallCount_q + 1'b1;
      end
    end
  end

  assign busy_vec    = busy;
  assign stall_count = stallCount_q;

endmodule

// File: tb/tb_lw_stall_scoreboard.sv
// Directed bench: two scoreboards (LOAD_LAT=1 wide counter, LOAD_LAT=3 with a 2-bit saturating counter) share one stimulus.
module tb_lw_stall_scoreboard;

  localparam logic [4:0] LW  = 5'b01000;
  localparam logic [4:0] SW  = 5'b00111;
  localparam logic [4:0] ADD = 5'b00001;

  logic        clock = 1'b0;
  logic        reset;
  logic        decValid, decIsNoop, decUsesRt, flush;
  logic [4:0]  decOpcode, decRd, decRs, decRt;
  logic        stall1, stall3;
  logic [31:0] busy1, busy3;
  logic [15:0] cnt1;
  logic [1:0]  cnt3;
  int          vectors    = 0;
  int          miscompares = 0;

  always #5 clock = ~clock;

  lw_stall_scoreboard #(.LOAD_LAT(1)) dut1 (
    .clock(clock), .reset(reset), .dec_valid(decValid), .dec_is_noop(decIsNoop),
    .dec_opcode(decOpcode), .dec_rd(decRd), .dec_rs(decRs), .dec_rt(decRt),
    .dec_uses_rt(decUsesRt), .flush(flush), .stall(stall1), .busy_vec(busy1),
    .stall_count(cnt1)
  );

  lw_stall_scoreboard #(.LOAD_LAT(3), .CNT_W(2)) dut3 (
    .clock(clock), .reset(reset), .dec_valid(decValid), .dec_is_noop(decIsNoop),
    .dec_opcode(decOpcode), .dec_rd(decRd), .dec_rs(decRs), .dec_rt(decRt),
    .dec_uses_rt(decUsesRt), .flush(flush), .stall(stall3), .busy_vec(busy3),
    .stall_count(cnt3)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic n, input logic [4:0] opc,
                               input logic [4:0] rd, input logic [4:0] rs, input logic [4:0] rt,
                               input logic u);
    decValid  = v;
    decIsNoop = n;
    decOpcode = opc;
    decRd     = rd;
    decRs     = rs;
    decRt     = rt;
    decUsesRt = u;
    #1;
  endtask

  task automatic idle();
    applyStimulus(1'b0, 1'b0, ADD, 5'd0, 5'd0, 5'd0, 1'b0);
  endtask

  task automatic nextCycle();
    @(posedge clock);
    #1;
  endtask

  task automatic checkStalls(input string tag, input logic e1, input logic e3);
    checkOutput({tag, "_stall1"}, 32'(stall1), 32'(e1));
    checkOutput({tag, "_stall3"}, 32'(stall3), 32'(e3));
  endtask

  initial begin
    reset = 1'b0;
    flush = 1'b0;
    idle();
    repeat (3) nextCycle();
    checkStalls("rst", 1'b0, 1'b0);
    checkOutput("rst_busy1", busy1, 32'h0);
    checkOutput("rst_cnt3", 32'(cnt3), 32'd0);
    reset = 1'b1;
    nextCycle();
    checkStalls("quiet", 1'b0, 1'b0);
    checkOutput("quiet_busy3", busy3, 32'h0);
    checkOutput("quiet_cnt1", 32'(cnt1), 32'd0);

    // Basic load-use on r5: one stall at LAT=1, three at LAT=3.
    applyStimulus(1'b1, 1'b0, LW, 5'd5, 5'd1, 5'd0, 1'b0);
    checkStalls("lw5", 1'b0, 1'b0);
    nextCycle();
    applyStimulus(1'b1, 1'b0, ADD, 5'd6, 5'd5, 5'd0, 1'b0);
    checkStalls("use5_c1", 1'b1, 1'b1);
    checkOutput("use5_busy1", busy1, 32'h20);
    checkOutput("use5_busy3", busy3, 32'h20);
    nextCycle();
    checkStalls("use5_c2", 1'b0, 1'b1);
    checkOutput("use5_busy1_clr", busy1, 32'h0);
    nextCycle();
    checkStalls("use5_c3", 1'b0, 1'b1);
    nextCycle();
    checkStalls("use5_c4", 1'b0, 1'b0);
    checkOutput("use5_cnt1", 32'(cnt1), 32'd1);
    checkOutput("use5_cnt3", 32'(cnt3), 32'd3);
    idle();
    nextCycle();

    // Consumer via rt; the LAT=3 counter is saturated at 3 and must stay there.
    applyStimulus(1'b1, 1'b0, LW, 5'd7, 5'd0, 5'd0, 1'b0);
    nextCycle();
    applyStimulus(1'b1, 1'b0, ADD, 5'd8, 5'd2, 5'd7, 1'b1);
    checkStalls("rt7_c1", 1'b1, 1'b1);
    nextCycle();
    checkStalls("rt7_c2", 1'b0, 1'b1);
    nextCycle();
    checkStalls("rt7_c3", 1'b0, 1'b1);
    nextCycle();
    checkStalls("rt7_c4", 1'b0, 1'b0);
    checkOutput("rt7_cnt1", 32'(cnt1), 32'd2);
    checkOutput("rt7_cnt3_sat", 32'(cnt3), 32'd3);
    idle();
    nextCycle();

    applyStimulus(1'b1, 1'b0, LW, 5'd7, 5'd0, 5'd0, 1'b0);
    nextCycle();
    applyStimulus(1'b1, 1'b0, ADD, 5'd8, 5'd2, 5'd7, 1'b0);
    checkStalls("rt7_nouse", 1'b0, 1'b0);
    nextCycle();
    idle();
    repeat (3) nextCycle();
    checkOutput("drain_busy3", busy3, 32'h0);

    // r0 is never busy; a bubble never stalls.
    applyStimulus(1'b1, 1'b0, LW, 5'd0, 5'd1, 5'd0, 1'b0);
    nextCycle();
    applyStimulus(1'b1, 1'b0, ADD, 5'd2, 5'd0, 5'd0, 1'b0);
    checkStalls("r0", 1'b0, 1'b0);
    checkOutput("r0_busy3", busy3, 32'h0);
    nextCycle();
    applyStimulus(1'b1, 1'b0, LW, 5'd4, 5'd1, 5'd0, 1'b0);
    nextCycle();
    applyStimulus(1'b1, 1'b1, ADD, 5'd2, 5'd4, 5'd0, 1'b0);
    checkStalls("noop", 1'b0, 1'b0);
    checkOutput("noop_busy3", busy3, 32'h10);
    nextCycle();
    idle();
    repeat (3) nextCycle();

    // A non-load writer to a busy register leaves the countdown running.
    applyStimulus(1'b1, 1'b0, LW, 5'd6, 5'd1, 5'd0, 1'b0);
    nextCycle();
    applyStimulus(1'b1, 1'b0, ADD, 5'd6, 5'd1, 5'd0, 1'b0);
    checkStalls("waw6", 1'b0, 1'b0);
    nextCycle();
    checkOutput("waw6_busy1", busy1, 32'h0);
    checkOutput("waw6_busy3", busy3, 32'h40);
    idle();
    repeat (3) nextCycle();

    // Flush masks the stall and clears the scoreboard.
    applyStimulus(1'b1, 1'b0, LW, 5'd9, 5'd1, 5'd0, 1'b0);
    nextCycle();
    flush = 1'b1;
    applyStimulus(1'b1, 1'b0, ADD, 5'd2, 5'd9, 5'd0, 1'b0);
    checkStalls("flush_mask", 1'b0, 1'b0);
    checkOutput("flush_busy3_pre", busy3, 32'h200);
    nextCycle();
    flush = 1'b0;
    applyStimulus(1'b1, 1'b0, ADD, 5'd2, 5'd9, 5'd0, 1'b0);
    checkStalls("post_flush", 1'b0, 1'b0);
    checkOutput("post_flush_busy3", busy3, 32'h0);
    nextCycle();

    // Asynchronous reset mid-countdown drops stall immediately.
    applyStimulus(1'b1, 1'b0, LW, 5'd9, 5'd1, 5'd0, 1'b0);
    nextCycle();
    applyStimulus(1'b1, 1'b0, ADD, 5'd2, 5'd9, 5'd0, 1'b0);
    checkStalls("pre_rst", 1'b1, 1'b1);
    reset = 1'b0;
    #1;
    checkStalls("async_rst", 1'b0, 1'b0);
    checkOutput("async_rst_busy3", busy3, 32'h0);
    checkOutput("async_rst_cnt1", 32'(cnt1), 32'd0);
    idle();
    nextCycle();
    reset = 1'b1;
    nextCycle();

    // Store whose data register is the pending load target.
    applyStimulus(1'b1, 1'b0, LW, 5'd3, 5'd1, 5'd0, 1'b0);
    nextCycle();
    applyStimulus(1'b1, 1'b0, SW, 5'd0, 5'd1, 5'd3, 1'b1);
`ifdef SW_FWD_EN
    checkStalls("swrt_c1", 1'b0, 1'b1);
`else
    checkStalls("swrt_c1", 1'b1, 1'b1);
`endif
    nextCycle();
    checkStalls("swrt_c2", 1'b0, 1'b1);
    nextCycle();
`ifdef SW_FWD_EN
    checkStalls("swrt_c3", 1'b0, 1'b0);
`else
    checkStalls("swrt_c3", 1'b0, 1'b1);
`endif
    nextCycle();
    checkStalls("swrt_c4", 1'b0, 1'b0);
`ifdef SW_FWD_EN
    checkOutput("swrt_cnt1", 32'(cnt1), 32'd0);
    checkOutput("swrt_cnt3", 32'(cnt3), 32'd2);
`else
    checkOutput("swrt_cnt1", 32'(cnt1), 32'd1);
    checkOutput("swrt_cnt3", 32'(cnt3), 32'd3);
`endif
    idle();
    nextCycle();

    // Store address hazard on rs is never forwarded.
    applyStimulus(1'b1, 1'b0, LW, 5'd3, 5'd1, 5'd0, 1'b0);
    nextCycle();
    applyStimulus(1'b1, 1'b0, SW, 5'd0, 5'd3, 5'd1, 1'b1);
    checkStalls("swrs_c1", 1'b1, 1'b1);
    nextCycle();
    checkStalls("swrs_c2", 1'b0, 1'b1);
    nextCycle();
    checkStalls("swrs_c3", 1'b0, 1'b1);
    nextCycle();
    checkStalls("swrs_c4", 1'b0, 1'b0);
`ifdef SW_FWD_EN
    checkOutput("swrs_cnt1", 32'(cnt1), 32'd1);
`else
    checkOutput("swrs_cnt1", 32'(cnt1), 32'd2);
`endif
    checkOutput("swrs_cnt3_sat", 32'(cnt3), 32'd3);
    idle();
    nextCycle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
